morse_decoder: RTL and testbench
================================

Name: morse_decoder

Overview:
- Receive side of the team's Morse link: timestamps a single keyed line, classifies each mark as dot or dash, and detects the end of a character from the following gap.
- Emits the character in the same packed form the encoder consumes: 4-bit code, element 0 in bit 0, 1 = dash, 0 = dot; plus a 3-bit element count.
- Sits between the key/button input conditioning and the character consumer. The consumer is either loopback-check logic or the encoder's load interface.

Parameters:
- DASH_TICKS, 3, minimum mark length in tick_i pulses classified as a dash; shorter marks are dots.
- GAP_TICKS, 3, space length in tick_i pulses that terminates a character.
- CNT_W, 8, width of the duration counter; the counter saturates at all-ones.

Ports:
- clk_i  input  1  system clock
- rst_ni  input  1  asynchronous active-low reset
- tick_i  input  1  single-cycle time-base strobe; one Morse time unit per pulse
- key_i  input  1  raw keyed line, 1 = mark; asynchronous to clk_i
- char_o  output  4  decoded code, element k in bit k, unused bits 0
- length_o  output  3  number of elements in char_o, 1..4
- valid_o  output  1  one-cycle strobe; char_o/length_o are new this cycle
- error_o  output  1  one-cycle strobe; character discarded (more than 4 elements)
- busy_o  output  1  high while a character is in progress (state != IDLE)

Behaviour:
- Reset (async assert, sync release): state IDLE, counter 0, element count 0, shift register 0, char_o 0, length_o 0, valid_o 0, error_o 0, busy_o 0, sync flops 0.
- key_i passes through a 2-flop synchronizer. key_s is the second flop. Rise and fall are detected against a third registered copy. Edge detection latency from key_i is 3 clk_i cycles.
- Duration counter:
  - cleared on every state change;
  - increments by 1 on each cycle with tick_i=1;
  - saturates at 2^CNT_W-1, no wrap.
- IDLE:
  - rise -> MARK, counter 0, element count 0, shift 0;
  - ticks ignored.
- MARK:
  - fall -> SPACE.
  - On the fall the element is classified: dash if counter >= DASH_TICKS, else dot. A fall before any tick is a dot.
  - If element count < 4: write the element bit at index element count, then increment element count.
  - If element count == 4: set the internal overflow flag and leave the shift register unchanged.
- SPACE:
  - rise with counter < GAP_TICKS -> MARK (next element).
  - Character end: on a cycle with tick_i=1 where counter+1 == GAP_TICKS -> IDLE.
    - Overflow flag clear: char_o <= shift, length_o <= element count, valid_o = 1 on the next cycle.
    - Overflow flag set: error_o = 1 on the next cycle; char_o/length_o keep their previous values; the overflow flag clears.
  - Rise and terminating tick in the same cycle: the rise wins (MARK). No emit.
- char_o/length_o hold their last emitted value until the next valid_o. valid_o and error_o are never both high. Each lasts exactly one cycle.
- busy_o is a registered decode of state != IDLE.
- Reset asserted mid-character: everything returns to reset values immediately. No valid_o or error_o for the partial character.
- tick_i high for several consecutive cycles counts once per cycle. No edge detection is applied to tick_i.

Test Plan (DASH_TICKS=3, GAP_TICKS=3; ticks every 4 clk_i cycles; key edges aligned mid-interval):
- Letter A: mark 1 tick, space 1, mark 3, space 3 -> exactly one valid_o; char_o=4'b0010, length_o=3'd2; busy_o high from the first mark until valid_o.
- Letter O: three marks of 4 ticks each, separated by 1-tick spaces, then 5-tick space -> char_o=4'b0111, length_o=3; one valid_o only, with no second emit as the space keeps running.
- Boundary classification: mark of 2 ticks then gap -> char_o=4'b0000, length_o=1; mark of exactly 3 ticks then gap -> char_o=4'b0001, length_o=1.
- Overflow: five 1-tick dots then gap -> error_o one cycle, valid_o never, char_o/length_o unchanged from prior letter. A following letter E (one dot) decodes to char_o=0, length_o=1.
- Gap boundary: space of 2 ticks between dot and dash -> single character 4'b0010/2. A rise in the same cycle as the 3rd space tick also yields a single character.
- Reset mid-character: rst_ni low after two dashes -> all outputs 0 within the same cycle. After release, a single dot -> char_o=0, length_o=1, one valid_o.

Source files
------------

// File: rtl/morse_decoder.sv
// Morse receive path: synchronises the keyed line, times marks and spaces
// against the tick strobe, classifies each mark as dot or dash and emits the
// packed character once the following space reaches the character gap.
module morse_decoder #(
  parameter int unsigned DASH_TICKS = 3,
  parameter int unsigned GAP_TICKS  = 3,
  parameter int unsigned CNT_W      = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       tick_i,
  input  logic       key_i,
  output logic [3:0] char_o,
  output logic [2:0] length_o,
  output logic       valid_o,
  output logic       error_o,
  output logic       busy_o
);

  localparam int unsigned MAX_ELEMS = 4;
  localparam int unsigned CODE_W    = 4;
  localparam int unsigned LEN_W     = 3;
  localparam int unsigned EXT_W     = CNT_W + 1;

  localparam logic [EXT_W-1:0] DASH_LIM = EXT_W'(DASH_TICKS);
  localparam logic [EXT_W-1:0] GAP_LIM  = EXT_W'(GAP_TICKS);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};
  localparam logic [LEN_W-1:0] ELEM_LIM = LEN_W'(MAX_ELEMS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MARK  = 2'd1,
    SPACE = 2'd2
  } stateE;

  stateE              state;
  stateE              stateNext;

  logic               keyMeta;
  logic               keySync;
  logic               keyDly;
  logic               keyRise;
  logic               keyFall;

  logic [CNT_W-1:0]   cnt;
  logic [EXT_W-1:0]   cntExt;
  logic [EXT_W-1:0]   cntInc;
  logic               isDash;
  logic               gapOpen;
  logic               gapDone;

  logic [LEN_W-1:0]   elemCnt;
  logic [CODE_W-1:0]  shiftReg;
  logic               ovf;

  logic               startChar;
  logic               recordElem;
  logic               emitChar;

  // Two-flop synchroniser plus a delayed copy for edge detection
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      keyMeta <= 1'b0;
      keySync <= 1'b0;
      keyDly  <= 1'b0;
    end else begin
      keyMeta <= key_i;
      keySync <= keyMeta;
      keyDly  <= keySync;
    end
  end

  assign keyRise = keySync & ~keyDly;
  assign keyFall = ~keySync & keyDly;

  // Counter comparisons are done one bit wider so the +1 never wraps
  assign cntExt  = {1'b0, cnt};
  assign cntInc  = cntExt + EXT_W'(1);
  assign isDash  = (cntExt >= DASH_LIM);
  assign gapOpen = (cntExt < GAP_LIM);
  assign gapDone = tick_i && (cntInc == GAP_LIM);

  // State register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state decode; a rise during the space beats the terminating tick
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (keyRise) begin
          stateNext = MARK;
        end
      end
      MARK: begin
        if (keyFall) begin
          stateNext = SPACE;
        end
      end
      SPACE: begin
        if (keyRise && gapOpen) begin
          stateNext = MARK;
        end else if (gapDone) begin
          stateNext = IDLE;
        end
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  // Per-state control strobes for the datapath
  always_comb begin
    startChar  = 1'b0;
    recordElem = 1'b0;
    emitChar   = 1'b0;
    case (state)
      IDLE: begin
        startChar = keyRise;
      end
      MARK: begin
        recordElem = keyFall;
      end
      SPACE: begin
        emitChar = !(keyRise && gapOpen) && gapDone;
      end
      default: begin
        startChar = 1'b0;
      end
    endcase
  end

  // Duration counter: cleared on state change, saturating tick count otherwise
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt <= '0;
    end else if (stateNext != state) begin
      cnt <= '0;
    end else if ((state != IDLE) && tick_i && (cnt != CNT_SAT)) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Element accumulation; a fifth element only marks the character as bad
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      elemCnt  <= '0;
      shiftReg <= '0;
      ovf      <= 1'b0;
    end else if (startChar) begin
      elemCnt  <= '0;
      shiftReg <= '0;
      ovf      <= 1'b0;
    end else if (recordElem) begin
      if (elemCnt < ELEM_LIM) begin
        shiftReg[elemCnt[1:0]] <= isDash;
        elemCnt                <= elemCnt + LEN_W'(1);
      end else begin
        ovf <= 1'b1;
      end
    end else if (emitChar) begin
      ovf <= 1'b0;
    end
  end

  // Registered character outputs and strobes; char/length hold between emits
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      char_o   <= '0;
      length_o <= '0;
      valid_o  <= 1'b0;
      error_o  <= 1'b0;
      busy_o   <= 1'b0;
    end else begin
      valid_o <= emitChar && !ovf;
      error_o <= emitChar && ovf;
      busy_o  <= (stateNext != IDLE);
      if (emitChar && !ovf) begin
        char_o   <= shiftReg;
        length_o <= elemCnt;
      end
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: directed letters and boundaries plus randomised
// characters, all checked against a tick-level model of the keying rules.
module tb_morse_decoder;

  localparam int DASH = 3;
  localparam int GAP  = 3;

  logic       clk = 1'b0;
  logic       rstN = 1'b1;
  logic       key = 1'b0;
  logic       tick;
  logic [1:0] tickPhase = 2'd0;
  logic [3:0] charO;
  logic [2:0] lengthO;
  logic       validO;
  logic       errorO;
  logic       busyO;

  int nTests = 0;
  int nFail  = 0;
  int validCnt = 0;
  int errCnt   = 0;
  int bothCnt  = 0;

  int         markLen [8];
  int         spaceLen[8];
  logic [3:0] expChar = 4'd0;
  logic [2:0] expLen  = 3'd0;

  morse_decoder #(
    .DASH_TICKS(DASH),
    .GAP_TICKS (GAP),
    .CNT_W     (8)
  ) dut (
    .clk_i   (clk),
    .rst_ni  (rstN),
    .tick_i  (tick),
    .key_i   (key),
    .char_o  (charO),
    .length_o(lengthO),
    .valid_o (validO),
    .error_o (errorO),
    .busy_o  (busyO)
  );

  always #5 clk = ~clk;

  // One tick every 4 clocks
  always @(posedge clk) tickPhase <= tickPhase + 2'd1;
  assign tick = (tickPhase == 2'd0);

  // Count strobe cycles away from the active edge
  always @(negedge clk) begin
    if (validO) validCnt++;
    if (errorO) errCnt++;
    if (validO && errorO) bothCnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nTests++;
    assert (obs === exp) else begin
      nFail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Put key edges mid-way between ticks
  task automatic alignPhase();
    waitCycles(1);
    while (tickPhase != 2'd3) waitCycles(1);
  endtask

  // Key n marks with the stored durations (in ticks), then a final gap
  task automatic sendChar(input int n, input int finalGap);
    alignPhase();
    for (int i = 0; i < n; i++) begin
      key = 1'b1;
      waitCycles(4 * markLen[i]);
      if (i == 0) chk("busy.mark", 32'(busyO), 32'd1);
      key = 1'b0;
      if (i < n - 1) waitCycles(4 * spaceLen[i]);
      else waitCycles(4 * finalGap + 8);
    end
  endtask

  // Model: dash iff mark >= DASH ticks; more than 4 elements is an error
  task automatic runChar(input string tag, input int n, input int finalGap);
    int         v0;
    int         e0;
    int         expV;
    int         expE;
    logic [3:0] code;
    v0   = validCnt;
    e0   = errCnt;
    code = 4'd0;
    for (int k = 0; k < n && k < 4; k++) code[k] = (markLen[k] >= DASH);
    if (n > 4) begin
      expV = 0;
      expE = 1;
    end else begin
      expV    = 1;
      expE    = 0;
      expChar = code;
      expLen  = 3'(n);
    end
    sendChar(n, finalGap);
    chk({tag, ".valid"}, 32'(validCnt - v0), 32'(expV));
    chk({tag, ".error"}, 32'(errCnt - e0), 32'(expE));
    chk({tag, ".char"}, 32'(charO), 32'(expChar));
    chk({tag, ".len"}, 32'(lengthO), 32'(expLen));
    chk({tag, ".idle"}, 32'(busyO), 32'd0);
  endtask

  initial begin
    int v0;
    int n;
    int g;

    // Reset state
    #1 rstN = 1'b0;
    waitCycles(3);
    chk("rst.char", 32'(charO), 32'd0);
    chk("rst.len", 32'(lengthO), 32'd0);
    chk("rst.valid", 32'(validO), 32'd0);
    chk("rst.error", 32'(errorO), 32'd0);
    chk("rst.busy", 32'(busyO), 32'd0);
    rstN = 1'b1;
    waitCycles(6);

    // Letter A: dot, dash
    markLen[0] = 1; spaceLen[0] = 1; markLen[1] = 3;
    runChar("A", 2, GAP);

    // Letter O with a long trailing space: one emit only
    markLen[0] = 4; spaceLen[0] = 1; markLen[1] = 4; spaceLen[1] = 1; markLen[2] = 4;
    runChar("O", 3, 5);
    v0 = validCnt;
    waitCycles(40);
    chk("O.noRepeat", 32'(validCnt - v0), 32'd0);

    // Dash threshold boundaries
    markLen[0] = 2;
    runChar("mark2", 1, GAP);
    markLen[0] = 3;
    runChar("mark3", 1, GAP);

    // Overflow: five dots, then E
    for (int i = 0; i < 5; i++) begin
      markLen[i] = 1;
      spaceLen[i] = 1;
    end
    runChar("ovf", 5, GAP);
    markLen[0] = 1;
    runChar("E", 1, GAP);

    // Two-tick inner space stays within the character
    markLen[0] = 1; spaceLen[0] = 2; markLen[1] = 3;
    runChar("gap2", 2, GAP);

    // Rise landing on the third space tick continues the character
    v0 = validCnt;
    alignPhase();
    key = 1'b1;
    waitCycles(4);
    key = 1'b0;
    waitCycles(4 * GAP - 1);
    key = 1'b1;
    waitCycles(13);
    key = 1'b0;
    waitCycles(4 * GAP + 8);
    chk("tie.valid", 32'(validCnt - v0), 32'd1);
    chk("tie.char", 32'(charO), 32'b0010);
    chk("tie.len", 32'(lengthO), 32'd2);
    expChar = 4'b0010;
    expLen  = 3'd2;

    // Very long mark: counter must saturate rather than wrap
    markLen[0] = 257;
    runChar("sat", 1, GAP);

    // Reset mid-character after two dashes
    v0 = validCnt;
    n  = errCnt;
    alignPhase();
    for (int i = 0; i < 2; i++) begin
      key = 1'b1;
      waitCycles(12);
      key = 1'b0;
      waitCycles(4);
    end
    chk("mid.busy", 32'(busyO), 32'd1);
    rstN = 1'b0;
    #1;
    chk("mid.char", 32'(charO), 32'd0);
    chk("mid.len", 32'(lengthO), 32'd0);
    chk("mid.busyRst", 32'(busyO), 32'd0);
    chk("mid.validRst", 32'(validO), 32'd0);
    chk("mid.errorRst", 32'(errorO), 32'd0);
    expChar = 4'd0;
    expLen  = 3'd0;
    waitCycles(3);
    rstN = 1'b1;
    waitCycles(30);
    chk("mid.noValid", 32'(validCnt - v0), 32'd0);
    chk("mid.noError", 32'(errCnt - n), 32'd0);
    markLen[0] = 1;
    runChar("afterRst", 1, GAP);

    // Randomised characters
    for (int r = 0; r < 20; r++) begin
      n = int'($urandom_range(5, 1));
      g = int'($urandom_range(GAP + 2, GAP));
      for (int i = 0; i < n; i++) begin
        markLen[i]  = int'($urandom_range(5, 1));
        spaceLen[i] = int'($urandom_range(GAP - 1, 1));
      end
      runChar("rand", n, g);
    end

    chk("exclusive", 32'(bothCnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
